// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller:
// FSM states, PC-source codes and the per-cycle control bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STALL_MEM  = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_TRAP_DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REDIR_JUMP = 2'd0,
        REDIR_TRAP = 2'd1,
        REDIR_MRET = 2'd2
    } redir_sel_e;

    typedef struct packed {
        logic       if_stall;
        logic       id_stall;
        logic       alu_stall;
        logic       if_flush;
        logic       id_flush;
        logic       alu_flush;
        logic       redirect;
        redir_sel_e sel;
    } ctrl_t;

    function automatic logic any_stall(ctrl_t c);
        return c.if_stall | c.id_stall | c.alu_stall;
    endfunction

    // Width of a down-counter able to hold the value n (at least one bit).
    function automatic int unsigned cnt_bits(int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the pipeline and stall/flush/redirect controls back to it.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) ();

    logic                 ld_use_i;
    logic                 mem_busy_i;
    logic                 jump_i;
    logic                 trap_enter_i;
    logic                 trap_exit_i;
    logic                 if_stall_o;
    logic                 id_stall_o;
    logic                 alu_stall_o;
    logic                 if_flush_o;
    logic                 id_flush_o;
    logic                 alu_flush_o;
    logic                 redirect_o;
    redir_sel_e           redirect_sel_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;

    modport master (
        output ld_use_i, mem_busy_i, jump_i, trap_enter_i, trap_exit_i,
        input  if_stall_o, id_stall_o, alu_stall_o,
        input  if_flush_o, id_flush_o, alu_flush_o,
        input  redirect_o, redirect_sel_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ld_use_i, mem_busy_i, jump_i, trap_enter_i, trap_exit_i,
        output if_stall_o, id_stall_o, alu_stall_o,
        output if_flush_o, id_flush_o, alu_flush_o,
        output redirect_o, redirect_sel_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: resolves load-use, memory-busy, jump and trap events
// into per-stage stall/flush controls and PC redirects, with event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH  = 2,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic      clk_sys_i,
    input  logic      rst_i,
    pipe_ctrl_if.slave bus
);

    localparam int unsigned MAX_LD = (FLUSH_DEPTH > DRAIN_CYCLES) ? FLUSH_DEPTH : DRAIN_CYCLES;
    localparam int unsigned TW     = cnt_bits(MAX_LD);
    localparam logic [TW-1:0] FLUSH_LD = TW'(FLUSH_DEPTH);
    localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_CYCLES);

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d;
    ctrl_t         ctl;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pend_d  = pend_q;
        ctl     = '0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.trap_enter_i || pend_q) begin
                    ctl.if_stall = 1'b1;
                    ctl.id_flush = 1'b1;
                    pend_d       = 1'b0;
                    tmr_d        = DRAIN_LD;
                    state_d      = ST_TRAP_DRAIN;
                end else if (bus.trap_exit_i || bus.jump_i) begin
                    ctl.redirect = 1'b1;
                    ctl.sel      = bus.trap_exit_i ? REDIR_MRET : REDIR_JUMP;
                    ctl.if_flush = 1'b1;
                    ctl.id_flush = 1'b1;
                    tmr_d        = FLUSH_LD;
                    state_d      = ST_FLUSH;
                end else if (bus.mem_busy_i) begin
                    ctl.if_stall  = 1'b1;
                    ctl.id_stall  = 1'b1;
                    ctl.alu_stall = 1'b1;
                    state_d       = ST_STALL_MEM;
                end else if (bus.ld_use_i) begin
                    ctl.if_stall  = 1'b1;
                    ctl.id_stall  = 1'b1;
                    ctl.alu_flush = 1'b1;
                end
            end
            ST_STALL_MEM: begin
                // A trap cannot enter while memory is busy; remember it for RUN.
                if (bus.trap_enter_i) begin
                    pend_d = 1'b1;
                end
                if (bus.mem_busy_i) begin
                    ctl.if_stall  = 1'b1;
                    ctl.id_stall  = 1'b1;
                    ctl.alu_stall = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (bus.trap_enter_i) begin
                    ctl.if_stall = 1'b1;
                    ctl.id_flush = 1'b1;
                    tmr_d        = DRAIN_LD;
                    state_d      = ST_TRAP_DRAIN;
                end else begin
                    ctl.id_flush = 1'b1;
                    tmr_d        = tmr_q - TW'(1);
                    if (tmr_q <= TW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_TRAP_DRAIN: begin
                if (tmr_q == '0) begin
                    ctl.redirect  = 1'b1;
                    ctl.sel       = REDIR_TRAP;
                    ctl.if_flush  = 1'b1;
                    ctl.id_flush  = 1'b1;
                    ctl.alu_flush = 1'b1;
                    tmr_d         = FLUSH_LD;
                    state_d       = ST_FLUSH;
                end else begin
                    ctl.if_stall = 1'b1;
                    ctl.id_flush = 1'b1;
                    if (!bus.mem_busy_i) begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Outputs are decoded from live inputs, so reset must mask them too.
        if (rst_i) begin
            ctl = '0;
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            tmr_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.if_stall_o     = ctl.if_stall;
    assign bus.id_stall_o     = ctl.id_stall;
    assign bus.alu_stall_o    = ctl.alu_stall;
    assign bus.if_flush_o     = ctl.if_flush;
    assign bus.id_flush_o     = ctl.id_flush;
    assign bus.alu_flush_o    = ctl.alu_flush;
    assign bus.redirect_o     = ctl.redirect;
    assign bus.redirect_sel_o = ctl.sel;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i (clk_sys_i),
        .rst_i (rst_i),
        .en_i  (any_stall(ctl)),
        .cnt_o (bus.stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i (clk_sys_i),
        .rst_i (rst_i),
        .en_i  (ctl.redirect),
        .cnt_o (bus.flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a timeline-based reference model.
module tb_pipe_ctrl;

    localparam int FD = 2;
    localparam int DC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_WIDTH(32)) bus ();
    pipe_ctrl_if #(.CNT_WIDTH(4))  bus4 ();

    assign bus4.ld_use_i     = bus.ld_use_i;
    assign bus4.mem_busy_i   = bus.mem_busy_i;
    assign bus4.jump_i       = bus.jump_i;
    assign bus4.trap_enter_i = bus.trap_enter_i;
    assign bus4.trap_exit_i  = bus.trap_exit_i;

    pipe_ctrl #(.FLUSH_DEPTH(FD), .DRAIN_CYCLES(DC), .CNT_WIDTH(32)) dut (
        .clk_sys_i (clk),
        .rst_i     (rst),
        .bus       (bus)
    );

    pipe_ctrl #(.FLUSH_DEPTH(FD), .DRAIN_CYCLES(DC), .CNT_WIDTH(4)) dut4 (
        .clk_sys_i (clk),
        .rst_i     (rst),
        .bus       (bus4)
    );

    // {if_stall, id_stall, alu_stall, if_flush, id_flush, alu_flush, redirect, sel[1:0]}
    logic [8:0] v32, v4;
    assign v32 = {bus.if_stall_o, bus.id_stall_o, bus.alu_stall_o, bus.if_flush_o,
                  bus.id_flush_o, bus.alu_flush_o, bus.redirect_o, 2'(bus.redirect_sel_o)};
    assign v4  = {bus4.if_stall_o, bus4.id_stall_o, bus4.alu_stall_o, bus4.if_flush_o,
                  bus4.id_flush_o, bus4.alu_flush_o, bus4.redirect_o, 2'(bus4.redirect_sel_o)};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint satv(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // Reference model: absolute-cycle timeline of controller obligations.
    int     cyc         = 0;
    int     flush_until = 0;   // wrong-path kill active while cyc < flush_until
    int     drain_need  = -1;  // non-busy drain cycles still owed; -1 when no trap pending entry
    bit     mem_wait    = 0;
    bit     pend        = 0;
    longint n_stall     = 0;
    longint n_redir     = 0;

    always @(negedge clk) begin
        bit tr, tx, j, mb, lu;
        bit s_if, s_id, s_alu, f_if, f_id, f_alu, rd;
        logic [1:0] sel;
        logic [8:0] e;
        if (rst) begin
            flush_until = 0;
            drain_need  = -1;
            mem_wait    = 0;
            pend        = 0;
            n_stall     = 0;
            n_redir     = 0;
            chk("rst_ctrl32", 64'(v32), 64'd0);
            chk("rst_ctrl4", 64'(v4), 64'd0);
            chk("rst_cnt32", 64'({bus.stall_cnt_o, bus.flush_cnt_o}), 64'd0);
            chk("rst_cnt4", 64'({bus4.stall_cnt_o, bus4.flush_cnt_o}), 64'd0);
        end else begin
            tr = bus.trap_enter_i; tx = bus.trap_exit_i; j = bus.jump_i;
            mb = bus.mem_busy_i;   lu = bus.ld_use_i;
            {s_if, s_id, s_alu, f_if, f_id, f_alu, rd} = '0;
            sel = 2'd0;
            if (drain_need == 0) begin
                rd = 1; sel = 2'd1; f_if = 1; f_id = 1; f_alu = 1;
                drain_need  = -1;
                flush_until = cyc + 1 + FD;
            end else if (drain_need > 0) begin
                s_if = 1; f_id = 1;
                if (!mb) drain_need--;
            end else if (cyc < flush_until) begin
                f_id = 1;
                if (tr) begin
                    s_if = 1; drain_need = DC; flush_until = 0;
                end
            end else if (mem_wait) begin
                if (tr) pend = 1;
                if (mb) begin s_if = 1; s_id = 1; s_alu = 1; end
                else mem_wait = 0;
            end else if (tr || pend) begin
                s_if = 1; f_id = 1; pend = 0; drain_need = DC;
            end else if (tx || j) begin
                rd = 1; sel = tx ? 2'd2 : 2'd0; f_if = 1; f_id = 1;
                flush_until = cyc + 1 + FD;
            end else if (mb) begin
                s_if = 1; s_id = 1; s_alu = 1; mem_wait = 1;
            end else if (lu) begin
                s_if = 1; s_id = 1; f_alu = 1;
            end
            e = {s_if, s_id, s_alu, f_if, f_id, f_alu, rd, sel};
            chk("ctrl32", 64'(v32), 64'(e));
            chk("ctrl4", 64'(v4), 64'(e));
            chk("stall_cnt32", 64'(bus.stall_cnt_o), 64'(satv(n_stall, 32)));
            chk("flush_cnt32", 64'(bus.flush_cnt_o), 64'(satv(n_redir, 32)));
            chk("stall_cnt4", 64'(bus4.stall_cnt_o), 64'(satv(n_stall, 4)));
            chk("flush_cnt4", 64'(bus4.flush_cnt_o), 64'(satv(n_redir, 4)));
            if (s_if || s_id || s_alu) n_stall++;
            if (rd) n_redir++;
        end
        cyc++;
    end

    task automatic drive(input bit tr, input bit tx, input bit j, input bit mb, input bit lu);
        @(posedge clk);
        #1;
        bus.trap_enter_i = tr;
        bus.trap_exit_i  = tx;
        bus.jump_i       = j;
        bus.mem_busy_i   = mb;
        bus.ld_use_i     = lu;
    endtask

    task automatic lit(input string name, input logic [8:0] exp);
        #2;
        chk(name, 64'(v32), 64'(exp));
    endtask

    initial begin
        bus.trap_enter_i = 0;
        bus.trap_exit_i  = 0;
        bus.jump_i       = 0;
        bus.mem_busy_i   = 0;
        bus.ld_use_i     = 0;
        #3;
        chk("reset_outputs", 64'(v32), 64'd0);
        chk("reset_stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Jump: same-cycle redirect, then FD cycles of id_flush.
        drive(0, 0, 1, 0, 0); lit("jump_redirect", 9'h034);
        drive(0, 0, 0, 0, 0); lit("jump_flush1", 9'h010);
        chk("jump_flush_cnt", 64'(bus.flush_cnt_o), 64'd1);
        drive(0, 0, 0, 0, 0); lit("jump_flush2", 9'h010);
        drive(0, 0, 0, 0, 0); lit("jump_done", 9'h000);

        // Three back-to-back load-use bubbles.
        repeat (3) begin
            drive(0, 0, 0, 0, 1); lit("ld_use_bubble", 9'h188);
        end
        drive(0, 0, 0, 0, 0); lit("ld_use_done", 9'h000);
        chk("ld_use_stall_cnt", 64'(bus.stall_cnt_o), 64'd3);

        // Trap entry while memory busy: drain holds for busy cycles.
        drive(1, 0, 0, 1, 0); lit("trap_entry", 9'h110);
        drive(0, 0, 0, 1, 0); lit("drain_busy", 9'h110);
        drive(0, 0, 0, 0, 0); lit("drain_1", 9'h110);
        drive(0, 0, 0, 0, 0); lit("drain_2", 9'h110);
        drive(0, 0, 0, 0, 0); lit("trap_redirect", 9'h03D);
        drive(0, 0, 0, 0, 0); lit("trap_flush1", 9'h010);
        drive(0, 0, 0, 0, 0); lit("trap_flush2", 9'h010);
        drive(0, 0, 0, 0, 0); lit("trap_done", 9'h000);
        chk("trap_stall_cnt", 64'(bus.stall_cnt_o), 64'd7);
        chk("trap_flush_cnt", 64'(bus.flush_cnt_o), 64'd2);

        // Trap beats a simultaneous jump.
        drive(1, 0, 1, 0, 0); lit("trap_vs_jump", 9'h110);
        drive(0, 0, 0, 0, 0); lit("tvj_drain1", 9'h110);
        drive(0, 0, 0, 0, 0); lit("tvj_drain2", 9'h110);
        drive(0, 0, 0, 0, 0); lit("tvj_redirect", 9'h03D);
        repeat (2) begin drive(0, 0, 0, 0, 0); lit("tvj_flush", 9'h010); end
        drive(0, 0, 0, 0, 0); lit("tvj_done", 9'h000);

        // Reset in the middle of a drain.
        drive(1, 0, 0, 0, 0); lit("rd_entry", 9'h110);
        drive(0, 0, 0, 0, 0); lit("rd_drain", 9'h110);
        rst = 1;
        #1;
        chk("rd_outputs_zero", 64'(v32), 64'd0);
        chk("rd_counters_zero", 64'({bus.stall_cnt_o, bus.flush_cnt_o}), 64'd0);
        @(posedge clk);
        #1 rst = 0;
        repeat (10) begin
            drive(0, 0, 0, 0, 0); lit("rd_no_redirect", 9'h000);
        end

        // 20 memory-stall cycles saturate the 4-bit counter at 15.
        repeat (20) begin
            drive(0, 0, 0, 1, 0); lit("mem_stall", 9'h1C0);
        end
        drive(0, 0, 0, 0, 0); lit("mem_release", 9'h000);
        chk("sat_stall_cnt4", 64'(bus4.stall_cnt_o), 64'd15);
        chk("sat_stall_cnt32", 64'(bus.stall_cnt_o), 64'd20);
        drive(0, 0, 0, 0, 0);

        // Random traffic with occasional mid-cycle reset pulses.
        repeat (3000) begin
            drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 25);
            rst = 0;
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 1;
            end
        end
        drive(0, 0, 0, 0, 0);
        rst = 0;
        repeat (4) drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
